// File: rtl/sdram_pkg.sv
// Shared defaults and drain-FSM encodings for the SDRAM write buffer.
package sdram_pkg;

   localparam int DEPTH_DEF  = 16;
   localparam int ADDR_W_DEF = 23;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_GAP  = 2'd2
   } drain_state_t;

endpackage

// File: rtl/sdram_wfifo_ram.sv
// Buffer storage: one synchronous write port, one asynchronous read port.
module sdram_wfifo_ram #(
   parameter int DEPTH = 16,
   parameter int W     = 39,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sdram_write_buffer.sv
// Capture-to-SDRAM write FIFO with a req/ack drain FSM and sticky overflow.
module sdram_write_buffer
   import sdram_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int PW     = $clog2(DEPTH),
   parameter int CW     = $clog2(DEPTH) + 1
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iWr_valid,
   input  logic [ADDR_W-1:0] iWr_addr,
   input  logic [DATA_W-1:0] iWr_data,
   output logic              oBusy,
   input  logic              iFlush,
   input  logic              iClr_ovf,
   output logic              oSDRAM_req,
   output logic [ADDR_W-1:0] oSDRAM_addr,
   output logic [DATA_W-1:0] oSDRAM_data,
   input  logic              iSDRAM_ack,
   output logic [CW-1:0]     oCount,
   output logic              oOverflow
);

   localparam int W = ADDR_W + DATA_W;

   drain_state_t state, state_nxt;
   logic [PW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic [W-1:0]  head;
   logic          full, pop, push, drop;

   assign full = (count == CW'(DEPTH));
   assign pop  = (state == ST_REQ) && iSDRAM_ack;
   assign push = iWr_valid && (!full || pop);
   assign drop = iWr_valid && full && !pop;

   sdram_wfifo_ram #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_ram (
      .clk   (iCLK),
      .we    (push && !iFlush),
      .waddr (wptr),
      .wdata ({iWr_addr, iWr_data}),
      .raddr (rptr),
      .rdata (head)
   );

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (iFlush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // A drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST)         oOverflow <= 1'b0;
      else if (drop)     oOverflow <= 1'b1;
      else if (iClr_ovf) oOverflow <= 1'b0;
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (count != '0) state_nxt = ST_REQ;
         ST_REQ:  if (iSDRAM_ack)  state_nxt = ST_GAP;
         ST_GAP:  state_nxt = (count != '0) ? ST_REQ : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      if (iFlush) state_nxt = ST_IDLE;
   end

   assign oSDRAM_req  = (state == ST_REQ);
   assign oSDRAM_addr = head[W-1:DATA_W];
   assign oSDRAM_data = head[DATA_W-1:0];
   assign oCount      = count;
   assign oBusy       = (count >= CW'(DEPTH - 2));

endmodule

// File: tb/tb_sdram_write_buffer.sv
// Directed self-checking bench for sdram_write_buffer.
module tb_sdram_write_buffer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_valid = 1'b0;
   logic [22:0] wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        busy;
   logic        flush = 1'b0;
   logic        clr_ovf = 1'b0;
   logic        req;
   logic [22:0] sd_addr;
   logic [15:0] sd_data;
   logic        ack = 1'b0;
   logic [4:0]  count;
   logic        ovf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sdram_write_buffer dut (
      .iCLK        (clk),
      .iRST        (rst_n),
      .iWr_valid   (wr_valid),
      .iWr_addr    (wr_addr),
      .iWr_data    (wr_data),
      .oBusy       (busy),
      .iFlush      (flush),
      .iClr_ovf    (clr_ovf),
      .oSDRAM_req  (req),
      .oSDRAM_addr (sd_addr),
      .oSDRAM_data (sd_data),
      .iSDRAM_ack  (ack),
      .oCount      (count),
      .oOverflow   (ovf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [22:0] a, input logic [15:0] d);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!req && n < 20) begin
         tick();
         n++;
      end
      check(tag, {31'd0, req}, 32'd1);
   endtask

   initial begin
      #2;
      check("rst_req", {31'd0, req}, 32'd0);
      check("rst_count", {27'd0, count}, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // single word latency and handshake
      push(23'h000010, 16'hA5B6);
      check("t1_count1", {27'd0, count}, 32'd1);
      check("t1_req_early", {31'd0, req}, 32'd0);
      tick();
      check("t1_req", {31'd0, req}, 32'd1);
      check("t1_addr", {9'd0, sd_addr}, 32'h000010);
      check("t1_data", {16'd0, sd_data}, 32'h0000A5B6);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("t1_req_gap", {31'd0, req}, 32'd0);
      check("t1_count0", {27'd0, count}, 32'd0);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      tick();
      check("t1_idle_ack_cnt", {27'd0, count}, 32'd0);
      check("t1_idle_req", {31'd0, req}, 32'd0);

      // fill to 16, busy threshold, overflow
      for (int i = 0; i < 16; i++) begin
         push(23'(i), 16'h1000 + 16'(i));
         check("t2_count", {27'd0, count}, 32'(i + 1));
         check("t2_busy", {31'd0, busy}, (i + 1 >= 14) ? 32'd1 : 32'd0);
      end
      check("t2_ovf_pre", {31'd0, ovf}, 32'd0);
      push(23'h7FFFFF, 16'hDEAD);
      check("t2_drop_count", {27'd0, count}, 32'd16);
      check("t2_ovf", {31'd0, ovf}, 32'd1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("t2_ovf_clr", {31'd0, ovf}, 32'd0);

      // full buffer: push and pop in same cycle
      wait_req("t3_req_wait");
      check("t3_head", {9'd0, sd_addr}, 32'd0);
      wr_valid = 1'b1;
      wr_addr  = 23'h000100;
      wr_data  = 16'hBEEF;
      ack      = 1'b1;
      tick();
      wr_valid = 1'b0;
      ack      = 1'b0;
      check("t3_count", {27'd0, count}, 32'd16);
      check("t3_ovf", {31'd0, ovf}, 32'd0);
      for (int k = 0; k < 16; k++) begin
         wait_req("t3_drain_wait");
         check("t3_addr", {9'd0, sd_addr},
               (k < 15) ? 32'(k + 1) : 32'h100);
         check("t3_data", {16'd0, sd_data},
               (k < 15) ? 32'h1000 + 32'(k + 1) : 32'hBEEF);
         ack = 1'b1;
         tick();
         ack = 1'b0;
      end
      check("t3_empty", {27'd0, count}, 32'd0);

      // ten words, ack on every third cycle
      for (int i = 0; i < 10; i++)
         push(23'h200 + 23'(i), 16'h0C00 + 16'(i));
      for (int k = 0; k < 10; k++) begin
         wait_req("t4_wait");
         tick();
         tick();
         check("t4_req_hold", {31'd0, req}, 32'd1);
         check("t4_addr", {9'd0, sd_addr}, 32'h200 + 32'(k));
         check("t4_data", {16'd0, sd_data}, 32'h0C00 + 32'(k));
         ack = 1'b1;
         tick();
         ack = 1'b0;
         check("t4_gap", {31'd0, req}, 32'd0);
         check("t4_count", {27'd0, count}, 32'(9 - k));
      end
      tick();
      check("t4_idle", {31'd0, req}, 32'd0);

      // flush with five words while requesting
      for (int i = 0; i < 5; i++)
         push(23'h300 + 23'(i), 16'h5500 + 16'(i));
      wait_req("t5_wait");
      check("t5_count5", {27'd0, count}, 32'd5);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("t5_flush_count", {27'd0, count}, 32'd0);
      check("t5_flush_req", {31'd0, req}, 32'd0);
      tick();
      check("t5_flush_idle", {31'd0, req}, 32'd0);

      // flush leaves a set overflow flag alone
      for (int i = 0; i < 17; i++)
         push(23'h400 + 23'(i), 16'(i));
      check("t5_ovf_set", {31'd0, ovf}, 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("t5_ovf_kept", {31'd0, ovf}, 32'd1);
      check("t5_busy_clr", {31'd0, busy}, 32'd0);

      // async reset mid-handshake
      push(23'h500, 16'h1111);
      push(23'h501, 16'h2222);
      wait_req("t6_wait");
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_req", {31'd0, req}, 32'd0);
      check("t6_count", {27'd0, count}, 32'd0);
      check("t6_ovf", {31'd0, ovf}, 32'd0);
      check("t6_busy", {31'd0, busy}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      check("t6_post_req", {31'd0, req}, 32'd0);
      check("t6_post_count", {27'd0, count}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
